mux_rr_sel_sequencer: RTL and testbench
=======================================

// Module: mux_rr_sel_sequencer
// PURPOSE
//  Round-robin select sequencer that sits directly upstream of the registered 8:1 byte mux.
//  Takes 8 channel request lines and drives the mux Sel/Enable pins with a fair, dwell-limited rotation.
//  Each channel holds the mux for a programmable number of cycles, or until its request drops.
//  Also reports one-hot Grant and a Switch pulse so that downstream capture logic can tag the data.
// PARAMETERS
//  N_CH     8   number of mux channels; must be a power of 2
//  SEL_W    3   select width, equal to log2(N_CH)
//  DWELL_W  4   width of the per-grant dwell count
// PORTS
//  Clock   in   1        single clock; all logic samples on the rising edge
//  Reset   in   1        synchronous, active-high reset
//  Req     in   N_CH     per-channel request, level-sensitive
//  Dwell   in   DWELL_W  cycles per grant; a value of 0 is treated as 1; sampled at each grant start
//  Hold    in   1        freezes the current grant and dwell counter
//  Sel     out  SEL_W    mux select, registered
//  Enable  out  1        mux enable, registered; high while any grant is active
//  Grant   out  N_CH     one-hot copy of Sel while Enable=1; otherwise 0
//  Switch  out  1        one-cycle pulse on the cycle that Sel takes a new grant
// BEHAVIOUR
//  Reset: Sel=0, Enable=0, Grant=0, Switch=0, ptr=N_CH-1, cnt=0, state=IDLE. Takes effect at the next edge.
//  Reset asserted mid-grant aborts the grant. The first request after reset searches from channel 0.
//  Search: pick(base) = first i with Req[i]=1, scanning base+1, base+2, ... wrapping modulo N_CH.
//   The scan ends with base itself, so a sole requester can be re-granted.
//  States: IDLE, GRANT.
//  IDLE:
//   - If |Req: at the next edge Sel=pick(ptr), Grant=onehot, Enable=1, Switch=1.
//     Also cnt=max(Dwell,1)-1 and ptr=new Sel; state goes to GRANT.
//   - Latency from Req rising to Enable high is 1 cycle.
//   - Else: stay in IDLE; Sel holds its last value, Enable=0, Grant=0.
//  GRANT, evaluated each cycle in priority order:
//   1. Hold=1: everything frozen (Sel, cnt, Grant); Switch=0. A Req drop is ignored while Hold=1.
//   2. Req[Sel]=0, or cnt==0: the grant ends.
//      - If |Req: re-grant from pick(Sel) at the same edge, with no bubble. Switch=1, cnt reloaded.
//      - Else: go to IDLE with Enable=0 and Grant=0.
//   3. Otherwise: cnt decrements; Switch=0.
//  Req drop and cnt expiry in the same cycle end the grant once; there is no double advance.
//  Switch is high only on edges where Sel/Grant load a new grant, including a self re-grant.
//  Sel never changes while Enable=1 except together with Switch=1.
//  Grant always equals (Enable ? 1<<Sel : 0).
//  Downstream mux output Y reflects the new Sel one cycle after Switch (mux register latency).
//  Dwell arithmetic is unsigned DWELL_W bits; the maximum grant length is 2^DWELL_W-1 cycles.
// STRUCTURE
//  Package mux_seq_pkg: N_CH, SEL_W, DWELL_W defaults; state_t enum {IDLE, GRANT}.
//  Sub-module rr_priority_pick: combinational rotating priority encoder.
//   Inputs: Req and base. Outputs: idx[SEL_W-1:0] and found.
//   Instantiated once and shared by the IDLE and GRANT paths.
//  Top module: state register, ptr, cnt, output registers.
// TESTING
//  1. Reset=1 for 2 cycles, Req=8'hFF -> Sel=0, Enable=0, Grant=0, Switch=0 throughout reset.
//  2. Req=8'hFF, Dwell=2 -> Sel sequence 0,0,1,1,...,7,7,0.
//     Switch pulses every 2 cycles; Grant one-hot matches Sel.
//  3. Req=8'b1000_0100, Dwell=4 -> grants 2 then 7 then 2, each for 4 cycles.
//     Dropping Req[7] after 1 cycle of its grant returns to 2 with no idle cycle.
//  4. Sole Req=8'h10, Dwell=0 -> Sel=4 stays, Enable=1, Switch=1 every cycle (self re-grant, dwell of 1).
//  5. Hold=1 for 5 cycles mid-grant, with Req[Sel] dropped during the hold -> Sel and cnt unchanged.
//     After Hold falls the grant ends on the next edge.
//  6. Reset=1 asserted mid-grant on ch5 -> next edge gives Enable=0, Grant=0, Sel=0.
//     With Req=8'h21, the next grant goes to ch0.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// Shared constants and state encoding for the round-robin mux select sequencer.
package mux_seq_pkg;

  localparam int N_CH    = 8;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: returns the first requesting channel after base,
// wrapping around and finishing on base itself so a sole requester can win again.
module rr_priority_pick #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] base,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Scan from the farthest offset down to base+1 so the closest requester wins;
  // the offset N_CH truncates to base itself, which gives it the lowest priority.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      if (req[base + SEL_W'(k)]) begin
        idx   = base + SEL_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sel_sequencer.sv
// Round-robin select sequencer driving the Sel/Enable pins of the registered
// 8:1 byte mux, with a per-grant dwell limit, a hold freeze and a Switch tag.
module mux_rr_sel_sequencer
  import mux_seq_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [N_CH-1:0]    req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               hold,
  output logic [SEL_W-1:0]   sel,
  output logic               enable,
  output logic [N_CH-1:0]    grant,
  output logic               switch
);

  state_t             state;
  state_t             nextState;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   nextPtr;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] nextCnt;
  logic [DWELL_W-1:0] loadCnt;
  logic [SEL_W-1:0]   nextSel;
  logic               nextEnable;
  logic [N_CH-1:0]    nextGrant;
  logic               nextSwitch;
  logic [SEL_W-1:0]   pickBase;
  logic [SEL_W-1:0]   pickIdx;
  logic               pickFound;

  // In GRANT ptr already equals sel, so one shared picker serves both paths.
  assign pickBase = (state == GRANT) ? sel : ptr;

  rr_priority_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) uPick (
    .req   (req),
    .base  (pickBase),
    .idx   (pickIdx),
    .found (pickFound)
  );

  // A dwell of zero behaves like a dwell of one: the grant lasts a single cycle.
  assign loadCnt = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // Next-state and next-output decisions for the IDLE/GRANT sequencer.
  always_comb begin
    nextState  = state;
    nextPtr    = ptr;
    nextCnt    = cnt;
    nextSel    = sel;
    nextEnable = enable;
    nextSwitch = 1'b0;
    unique case (state)
      IDLE: begin
        if (pickFound) begin
          nextState  = GRANT;
          nextSel    = pickIdx;
          nextPtr    = pickIdx;
          nextCnt    = loadCnt;
          nextEnable = 1'b1;
          nextSwitch = 1'b1;
        end else begin
          nextEnable = 1'b0;
        end
      end
      GRANT: begin
        if (hold) begin
          nextSwitch = 1'b0;
        end else if (!req[sel] || (cnt == '0)) begin
          if (pickFound) begin
            nextSel    = pickIdx;
            nextPtr    = pickIdx;
            nextCnt    = loadCnt;
            nextEnable = 1'b1;
            nextSwitch = 1'b1;
          end else begin
            nextState  = IDLE;
            nextEnable = 1'b0;
          end
        end else begin
          nextCnt = cnt - DWELL_W'(1);
        end
      end
      default: begin
        nextState  = IDLE;
        nextEnable = 1'b0;
      end
    endcase
    nextGrant = nextEnable ? (N_CH'(1) << nextSel) : '0;
  end

  // State, pointer, counter and all mux-facing outputs register together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= SEL_W'(N_CH - 1);
      cnt    <= '0;
      sel    <= '0;
      enable <= 1'b0;
      grant  <= '0;
      switch <= 1'b0;
    end else begin
      state  <= nextState;
      ptr    <= nextPtr;
      cnt    <= nextCnt;
      sel    <= nextSel;
      enable <= nextEnable;
      grant  <= nextGrant;
      switch <= nextSwitch;
    end
  end

endmodule

// File: tb/tb_mux_rr_sel_sequencer.sv
// Directed bench for the round-robin mux select sequencer.
module tb_mux_rr_sel_sequencer;

  logic       clock;
  logic       reset;
  logic [7:0] req;
  logic [3:0] dwell;
  logic       hold;
  logic [2:0] sel;
  logic       enable;
  logic [7:0] grant;
  logic       switch;

  int checks;
  int failures;

  mux_rr_sel_sequencer dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .dwell  (dwell),
    .hold   (hold),
    .sel    (sel),
    .enable (enable),
    .grant  (grant),
    .switch (switch)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic applyStimulus(input logic r, input logic [7:0] rq,
                               input logic [3:0] dw, input logic h);
    reset = r;
    req   = rq;
    dwell = dw;
    hold  = h;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] expSel,
                             input logic expEn, input logic expSw);
    logic [7:0] expGrant;
    expGrant = expEn ? (8'd1 << expSel) : 8'd0;
    checks++;
    assert (sel === expSel) else begin
      failures++;
      $error("[TB] FAIL %s sel got=%0d exp=%0d", tag, sel, expSel);
    end
    checks++;
    assert (enable === expEn) else begin
      failures++;
      $error("[TB] FAIL %s enable got=%0b exp=%0b", tag, enable, expEn);
    end
    checks++;
    assert (grant === expGrant) else begin
      failures++;
      $error("[TB] FAIL %s grant got=%h exp=%h", tag, grant, expGrant);
    end
    checks++;
    assert (switch === expSw) else begin
      failures++;
      $error("[TB] FAIL %s switch got=%0b exp=%0b", tag, switch, expSw);
    end
  endtask

  // Directed sequence; inputs change 1 time unit after each rising edge.
  initial begin
    checks   = 0;
    failures = 0;

    // Reset held for two edges with every channel requesting.
    applyStimulus(1'b1, 8'hFF, 4'd2, 1'b0);
    tick(); checkOutput("reset0", 3'd0, 1'b0, 1'b0);
    tick(); checkOutput("reset1", 3'd0, 1'b0, 1'b0);

    // Full rotation with dwell 2: 0,0,1,1,...,7,7,0.
    applyStimulus(1'b0, 8'hFF, 4'd2, 1'b0);
    for (int i = 0; i < 17; i++) begin
      tick();
      checkOutput($sformatf("rot%0d", i), 3'((i / 2) % 8), 1'b1, (i % 2) == 0);
    end

    // Two requesters with dwell 4: 2 -> 7 -> 2.
    applyStimulus(1'b0, 8'b1000_0100, 4'd4, 1'b0);
    tick(); checkOutput("pair2a_start", 3'd2, 1'b1, 1'b1);
    tick(); checkOutput("pair2a_1", 3'd2, 1'b1, 1'b0);
    tick(); checkOutput("pair2a_2", 3'd2, 1'b1, 1'b0);
    tick(); checkOutput("pair2a_3", 3'd2, 1'b1, 1'b0);
    tick(); checkOutput("pair7_start", 3'd7, 1'b1, 1'b1);
    tick(); checkOutput("pair7_1", 3'd7, 1'b1, 1'b0);
    tick(); checkOutput("pair7_2", 3'd7, 1'b1, 1'b0);
    tick(); checkOutput("pair7_3", 3'd7, 1'b1, 1'b0);
    tick(); checkOutput("pair2b_start", 3'd2, 1'b1, 1'b1);
    tick(); checkOutput("pair2b_1", 3'd2, 1'b1, 1'b0);
    tick(); checkOutput("pair2b_2", 3'd2, 1'b1, 1'b0);
    tick(); checkOutput("pair2b_3", 3'd2, 1'b1, 1'b0);
    tick(); checkOutput("pair7b_start", 3'd7, 1'b1, 1'b1);

    // Req[7] drops after one cycle of its grant: straight back to 2.
    applyStimulus(1'b0, 8'b0000_0100, 4'd4, 1'b0);
    tick(); checkOutput("drop7_back2", 3'd2, 1'b1, 1'b1);

    // Sole requester 4 with dwell 0: self re-grant every cycle.
    applyStimulus(1'b0, 8'h10, 4'd0, 1'b0);
    tick(); checkOutput("sole4_0", 3'd4, 1'b1, 1'b1);
    tick(); checkOutput("sole4_1", 3'd4, 1'b1, 1'b1);
    tick(); checkOutput("sole4_2", 3'd4, 1'b1, 1'b1);
    tick(); checkOutput("sole4_3", 3'd4, 1'b1, 1'b1);

    // Reload ch4 with dwell 5, then hold 5 cycles while req[4] drops.
    applyStimulus(1'b0, 8'h10, 4'd5, 1'b0);
    tick(); checkOutput("h4_load", 3'd4, 1'b1, 1'b1);
    tick(); checkOutput("h4_dec", 3'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h20, 4'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("hold4_%0d", i), 3'd4, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 8'h20, 4'd5, 1'b0);
    tick(); checkOutput("unhold_to5", 3'd5, 1'b1, 1'b1);

    // Counter must stay frozen across a hold: 4 counted cycles remain after it.
    tick(); checkOutput("c5_dec", 3'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h20, 4'd5, 1'b1);
    tick(); checkOutput("c5_hold0", 3'd5, 1'b1, 1'b0);
    tick(); checkOutput("c5_hold1", 3'd5, 1'b1, 1'b0);
    tick(); checkOutput("c5_hold2", 3'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h20, 4'd5, 1'b0);
    tick(); checkOutput("c5_run2", 3'd5, 1'b1, 1'b0);
    tick(); checkOutput("c5_run1", 3'd5, 1'b1, 1'b0);
    tick(); checkOutput("c5_run0", 3'd5, 1'b1, 1'b0);
    tick(); checkOutput("c5_regrant", 3'd5, 1'b1, 1'b1);
    tick(); checkOutput("c5_mid", 3'd5, 1'b1, 1'b0);

    // Reset mid-grant on ch5, then ch0 wins from the reset pointer.
    applyStimulus(1'b1, 8'h21, 4'd5, 1'b0);
    tick(); checkOutput("midreset", 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h21, 4'd5, 1'b0);
    tick(); checkOutput("after_reset_ch0", 3'd0, 1'b1, 1'b1);

    // All requests gone: back to IDLE, sel keeps its value.
    applyStimulus(1'b0, 8'h00, 4'd5, 1'b0);
    tick(); checkOutput("idle0", 3'd0, 1'b0, 1'b0);
    tick(); checkOutput("idle1", 3'd0, 1'b0, 1'b0);

    // From IDLE the search starts after the last grant (ch0), so ch1 wins.
    applyStimulus(1'b0, 8'h22, 4'd5, 1'b0);
    tick(); checkOutput("idle_regrant1", 3'd1, 1'b1, 1'b1);

    // Reset restores the pointer to 7, so ch0 beats ch7.
    applyStimulus(1'b1, 8'h81, 4'd5, 1'b0);
    tick(); checkOutput("reset_b", 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h81, 4'd5, 1'b0);
    tick(); checkOutput("ptr_reset_ch0", 3'd0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
